// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the multiply sequencer state type.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // ALU opcodes as decoded by the shared EX-stage ALU.
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_NOR   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_PASSA = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;
    localparam logic [3:0] ALU_ADD8  = 4'b1100;

    // Multiply sequencer states.
    typedef enum logic [1:0] {
        MUL_IDLE  = 2'd0,
        MUL_ADD   = 2'd1,
        MUL_SHIFT = 2'd2,
        MUL_DONE  = 2'd3
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer. Borrows the shared ALU one operation per
// cycle (ADD of the partial product, then SLL of the multiplicand) and keeps
// the low word of the product in acc.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int         WIDTH  = ALU_WIDTH,
    parameter logic [3:0] OP_ADD = ALU_ADD,
    parameter logic [3:0] OP_SLL = ALU_SLL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out
);

    mul_state_e       state;
    mul_state_e       state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;

    // True when the multiplier has no set bits left after this shift.
    logic             last_shift;
    assign last_shift = (mplr[WIDTH-1:1] == '0);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus status and ALU drive for the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        alu_op     = OP_ADD;
        alu_a      = '0;
        alu_b      = '0;
        unique case (state)
            MUL_IDLE: begin
                if (start) begin
                    state_next = (b == '0) ? MUL_DONE : MUL_ADD;
                end
            end
            MUL_ADD: begin
                busy       = 1'b1;
                alu_a      = acc;
                alu_b      = mcand;
                state_next = MUL_SHIFT;
            end
            MUL_SHIFT: begin
                busy       = 1'b1;
                alu_op     = OP_SLL;
                alu_a      = WIDTH'(1);
                alu_b      = mcand;
                state_next = last_shift ? MUL_DONE : MUL_ADD;
            end
            MUL_DONE: begin
                done       = 1'b1;
                state_next = MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    // Datapath registers: load operands on start, accumulate and shift from ALU output.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, because result must read 0 after reset.
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
        end else begin
            unique case (state)
                MUL_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mcand <= a;
                        mplr  <= b;
                    end
                end
                MUL_ADD: begin
                    if (mplr[0]) begin
                        acc <= alu_out;
                    end
                end
                MUL_SHIFT: begin
                    mcand <= alu_out;
                    mplr  <= mplr >> 1;
                end
                default: ;
            endcase
        end
    end

    assign result = acc;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed cases from the test plan plus
// random operands, compared against a plain-arithmetic reference model.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;

    int errors = 0;
    int checks = 0;

    alu_mul_seq #(.WIDTH(32), .OP_ADD(ALU_ADD), .OP_SLL(ALU_SLL)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .alu_op  (alu_op),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_out (alu_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU (only the opcodes this block uses matter).
    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SLL: alu_out = alu_b << alu_a[4:0];
            default: alu_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference latency: 1 cycle for b==0, else 2*(msb index+1)+1.
    function automatic int model_latency(input logic [31:0] mb);
        int k;
        k = -1;
        for (int i = 0; i < 32; i++) begin
            if (mb[i]) k = i;
        end
        return (k < 0) ? 1 : 2 * (k + 1) + 1;
    endfunction

    // Issue one multiply and check timing, ALU usage, result and post-done idle.
    // pulse_at >= 1 raises a stray start during that busy cycle.
    task automatic run_mul(input logic [31:0] op_a, input logic [31:0] op_b,
                           input int pulse_at, input string tag);
        logic [31:0] exp_prod;
        int          exp_lat;
        int          lat;
        exp_prod = op_a * op_b;
        exp_lat  = model_latency(op_b);
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat   = -1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (done) begin
                lat = cyc;
                break;
            end
            check({tag, " busy"}, {31'b0, busy}, 32'd1);
            check({tag, " alu_op"}, {28'b0, alu_op}, (cyc % 2 == 1) ? 32'(ALU_ADD) : 32'(ALU_SLL));
            if (cyc % 2 == 0) check({tag, " sll_amount"}, alu_a, 32'd1);
            start = (cyc == pulse_at);
            if (cyc == pulse_at) begin
                a = $urandom;
                b = $urandom | 32'h1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp_prod);
        check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'b0, done}, 32'd0);
        check({tag, " result_held"}, result, exp_prod);
        check({tag, " idle_alu_a"}, alu_a, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset held two cycles, then idle.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset alu_op", {28'b0, alu_op}, 32'(ALU_ADD));
        check("reset alu_b", alu_b, 32'd0);

        // Directed cases.
        run_mul(32'd7, 32'd3, -1, "small");
        run_mul(32'h12345678, 32'd0, -1, "zero_b");
        run_mul(32'hFFFFFFFD, 32'd5, -1, "signed");
        run_mul(32'h00010000, 32'h00010000, -1, "wrap");
        run_mul(32'd1, 32'h80000000, 10, "worst");

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst alu_op", {28'b0, alu_op}, 32'(ALU_ADD));
        for (int i = 0; i < 8; i++) begin
            check("midrst no_done", {31'b0, done}, 32'd0);
            @(negedge clk);
        end
        run_mul(32'd6, 32'd4, -1, "after_rst");

        // Start in the same cycle as reset is dropped by reset.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start busy", {31'b0, busy}, 32'd0);
        check("rst_start done", {31'b0, done}, 32'd0);
        check("rst_start result", result, 32'd0);

        // Random operands with varied multiplier lengths.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 7 == 0) rb = '0;
            run_mul(ra, rb, (i % 3 == 0) ? 1 : -1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle controller that computes a 32-bit MUL (low word of the product) by driving the shared ALU through a shift-and-add sequence.
- Issues one ALU operation per cycle (ADD, then SLL) and captures the ALU output into internal registers.
- Sits beside the ALU in the EX stage: the pipeline raises start and stalls on busy; an external mux grants the ALU ports to this block while busy.

Parameters:
- WIDTH, 32, operand/result width; must match ALU width.
- OP_ADD, 4'b0000, ALU opcode for addition.
- OP_SLL, 4'b0110, ALU opcode for shift left logical (Out = B << A).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- busy  out  1  high in ADD and SHIFT states.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  product low word; held until the next accepted start.
- alu_op  out  4  opcode to ALU.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_out  in  WIDTH  ALU result (combinational, same cycle).

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE; acc, mcand, mplr, result = 0; busy=0; done=0. Reset mid-operation aborts without a done pulse.
- Internal registers: acc (accumulator, drives result), mcand (multiplicand), mplr (multiplier).
- States: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - ALU drive: alu_op=OP_ADD, alu_a=0, alu_b=0.
  - On start: acc<=0, mcand<=a, mplr<=b; next is DONE if b==0, else ADD.
- ADD:
  - Drive alu_op=OP_ADD, alu_a=acc, alu_b=mcand.
  - If mplr[0]=1, acc<=alu_out; else acc holds.
  - Next state: SHIFT.
- SHIFT:
  - Drive alu_op=OP_SLL, alu_a=1, alu_b=mcand.
  - mcand<=alu_out; mplr<=mplr>>1 (logical).
  - Next is DONE if (mplr>>1)==0, else ADD.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - ALU drive same as IDLE.
  - Next state: IDLE unconditionally; start is ignored in DONE.
- start while busy or in DONE: ignored, no queuing.
- Arithmetic: all sums are modulo 2^WIDTH; overflow discarded.
  - The low word is identical for signed and unsigned operands; no sign handling.
- Latency: with start accepted at cycle 0:
  - b==0: done at cycle 1.
  - Otherwise, with k = index of the highest set bit of b: done at cycle 2(k+1)+1. Worst case (b[31]=1) is cycle 65.
- result equals acc; it is only meaningful when done=1 and persists through IDLE.
- A start asserted in the same cycle as rst is ignored (reset wins).

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants (ADD, SUB, AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, PASSA, PASSB, ADD8).
  - The state enum for this block, encoded IDLE=0, ADD=1, SHIFT=2, DONE=3.
- No sub-module: a single FSM with its datapath registers. The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle: hold rst for 2 cycles, then start=0 -> busy=0, done=0, result=0, alu_op=0000.
- Small product: a=7, b=3 -> done at cycle 5, result=21; alu_op alternates 0000/0110 over cycles 1-4.
- Zero multiplier: a=0x12345678, b=0 -> done at cycle 1, result=0, busy never high.
- Signed/overflow: a=0xFFFFFFFD (-3), b=5 -> result=0xFFFFFFF1 at cycle 7; a=0x10000, b=0x10000 -> result=0 (wrap).
- Worst case: a=1, b=0x80000000 -> done at cycle 65, result=0x80000000; a start pulse at cycle 10 is ignored and the result is unchanged.
- Reset mid-operation: a=7, b=3, rst at cycle 2 -> no done pulse, state IDLE, result=0; a following start with a=6, b=4 gives done=1, result=24.
